// File: rtl/text_writer.sv
// text_writer: write-side controller for the character text buffer.
// Accepts PUT / NEWLINE / BACKSPACE / CLEAR over a valid/ready handshake,
// tracks the cursor and drives a registered buffer write port.
// Handshake: an op is taken on a rising edge where valid && ready. The source
// must hold op/char_in stable while valid is high and not yet taken. ready is
// high only in IDLE. valid seen while ready is low is ignored, not queued.
module text_writer #(
   parameter int          COLS  = 80,
   parameter int          ROWS  = 30,
   parameter logic [3:0]  BLANK = 4'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  op,
   input  logic [3:0]  char_in,
   input  logic        valid,
   output logic        ready,
   output logic [11:0] waddr,
   output logic [3:0]  new_char,
   output logic        we,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row
);

   localparam logic [1:0]  OP_PUT   = 2'd0;
   localparam logic [1:0]  OP_NL    = 2'd1;
   localparam logic [1:0]  OP_BS    = 2'd2;
   localparam logic [1:0]  OP_CLR   = 2'd3;
   localparam logic [11:0] COLS_A   = 12'(COLS);
   localparam logic [11:0] CELLS_A  = 12'(COLS * ROWS);
   localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

   typedef enum logic [1:0] {S_CLEAR, S_LINE_CLR, S_IDLE} state_t;

   state_t      state, state_d;
   logic [6:0]  col, col_d;
   logic [4:0]  row, row_d;
   logic [11:0] base, base_d;        // linear address of column 0 of the cursor row
   logic [11:0] cur, cur_d;          // linear address of the cursor cell
   logic [11:0] clr_addr, clr_addr_d; // next address to blank
   logic [11:0] clr_cnt, clr_cnt_d;   // blank writes already issued
   logic [11:0] waddr_d;
   logic [3:0]  new_char_d;
   logic        we_d;
   logic [11:0] clr_limit;
   logic [11:0] next_base;
   logic [4:0]  next_row;

   // Row that the cursor moves to on a line break (bottom row wraps to top).
   assign next_row  = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
   assign next_base = (row == LAST_ROW) ? 12'd0 : base + COLS_A;
   assign clr_limit = (state == S_CLEAR) ? CELLS_A : COLS_A;

   assign ready      = (state == S_IDLE);
   assign cursor_col = col;
   assign cursor_row = row;

   // Next-state, cursor and write-port decode.
   always_comb begin
      state_d    = state;
      col_d      = col;
      row_d      = row;
      base_d     = base;
      cur_d      = cur;
      clr_addr_d = clr_addr;
      clr_cnt_d  = clr_cnt;
      waddr_d    = waddr;
      new_char_d = new_char;
      we_d       = 1'b0;
      case (state)
         S_CLEAR, S_LINE_CLR: begin
            // One idle cycle after the last blank before handing back ready.
            if (clr_cnt == clr_limit) begin
               state_d = S_IDLE;
            end else begin
               we_d       = 1'b1;
               waddr_d    = clr_addr;
               new_char_d = BLANK;
               clr_addr_d = clr_addr + 12'd1;
               clr_cnt_d  = clr_cnt + 12'd1;
            end
         end
         S_IDLE: begin
            if (valid) begin
               case (op)
                  OP_PUT: begin
                     we_d       = 1'b1;
                     waddr_d    = cur;
                     new_char_d = char_in;
                     if (col != LAST_COL) begin
                        col_d = col + 7'd1;
                        cur_d = cur + 12'd1;
                     end else begin
                        // Line full: blank the new row, first blank next cycle.
                        col_d      = 7'd0;
                        row_d      = next_row;
                        base_d     = next_base;
                        cur_d      = next_base;
                        clr_addr_d = next_base;
                        clr_cnt_d  = 12'd0;
                        state_d    = S_LINE_CLR;
                     end
                  end
                  OP_NL: begin
                     // First blank of the new row is issued right away.
                     col_d      = 7'd0;
                     row_d      = next_row;
                     base_d     = next_base;
                     cur_d      = next_base;
                     we_d       = 1'b1;
                     waddr_d    = next_base;
                     new_char_d = BLANK;
                     clr_addr_d = next_base + 12'd1;
                     clr_cnt_d  = 12'd1;
                     state_d    = S_LINE_CLR;
                  end
                  OP_BS: begin
                     if (col != 7'd0) begin
                        col_d      = col - 7'd1;
                        cur_d      = cur - 12'd1;
                        we_d       = 1'b1;
                        waddr_d    = cur - 12'd1;
                        new_char_d = BLANK;
                     end else if (row != 5'd0) begin
                        col_d      = LAST_COL;
                        row_d      = row - 5'd1;
                        base_d     = base - COLS_A;
                        cur_d      = cur - 12'd1;
                        we_d       = 1'b1;
                        waddr_d    = cur - 12'd1;
                        new_char_d = BLANK;
                     end
                  end
                  default: begin
                     col_d      = 7'd0;
                     row_d      = 5'd0;
                     base_d     = 12'd0;
                     cur_d      = 12'd0;
                     we_d       = 1'b1;
                     waddr_d    = 12'd0;
                     new_char_d = BLANK;
                     clr_addr_d = 12'd1;
                     clr_cnt_d  = 12'd1;
                     state_d    = S_CLEAR;
                  end
               endcase
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // State register; reset restarts the full-screen clear from the top.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_CLEAR;
         col      <= 7'd0;
         row      <= 5'd0;
         base     <= 12'd0;
         cur      <= 12'd0;
         clr_addr <= 12'd0;
         clr_cnt  <= 12'd0;
         waddr    <= 12'd0;
         new_char <= 4'd0;
         we       <= 1'b0;
      end else begin
         state    <= state_d;
         col      <= col_d;
         row      <= row_d;
         base     <= base_d;
         cur      <= cur_d;
         clr_addr <= clr_addr_d;
         clr_cnt  <= clr_cnt_d;
         waddr    <= waddr_d;
         new_char <= new_char_d;
         we       <= we_d;
      end
   end

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: cursor/screen reference model feeding an expected
// write queue; a monitor pops and compares every buffer write.
module tb_text_writer;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [3:0] BLANK = 4'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op_r = 2'd0;
  logic [3:0]  char_r = 4'd0;
  logic        valid = 1'b0;
  logic        ready;
  logic [11:0] waddr;
  logic [3:0]  new_char;
  logic        we;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int m_row = 0;
  int m_col = 0;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .op(op_r), .char_in(char_r), .valid(valid),
    .ready(ready), .waddr(waddr), .new_char(new_char), .we(we),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // reference model
  task automatic push_w(input int addr, input logic [3:0] d);
    exp_q.push_back({12'(addr), d});
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < COLS; c++) push_w(r * COLS + c, BLANK);
  endtask

  task automatic model_apply(input logic [1:0] o, input logic [3:0] c, output int gap);
    gap = 0;
    case (o)
      2'd0: begin
        push_w(m_row * COLS + m_col, c);
        if (m_col == COLS - 1) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
          push_row(m_row);
          gap = COLS + 1;
        end else m_col++;
      end
      2'd1: begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        push_row(m_row);
        gap = COLS;
      end
      2'd2: begin
        if (m_col > 0) begin
          m_col--;
          push_w(m_row * COLS + m_col, BLANK);
        end else if (m_row > 0) begin
          m_row--;
          m_col = COLS - 1;
          push_w(m_row * COLS + m_col, BLANK);
        end
      end
      default: begin
        for (int a = 0; a < CELLS; a++) push_w(a, BLANK);
        m_row = 0;
        m_col = 0;
        gap = CELLS;
      end
    endcase
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (we) begin
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("write_addr", int'(waddr), int'(e[15:4]));
        chk("write_data", int'(new_char), int'(e[3:0]));
      end
    end
  end

  task automatic count_gap(input int gap);
    int t = 0;
    while (!ready && t < 5000) begin
      step();
      t++;
    end
    chk("ready_gap", t, gap);
  endtask

  // driver: present op, wait for acceptance, land in cycle 1
  task automatic accept_op(input logic [1:0] o, input logic [3:0] c, output int gap);
    int t = 0;
    op_r = o;
    char_r = c;
    valid = 1'b1;
    while (!ready && t < 5000) begin
      step();
      t++;
    end
    if (!ready) chk("accept_timeout", 0, 1);
    model_apply(o, c, gap);
    step();
    valid = 1'b0;
    chk("cursor_col", int'(cursor_col), m_col);
    chk("cursor_row", int'(cursor_row), m_row);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [3:0] c);
    int gap;
    accept_op(o, c, gap);
    count_gap(gap);
  endtask

  initial begin
    int gap;
    // reset state
    repeat (3) step();
    chk("rst_we", int'(we), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_new_char", int'(new_char), 0);
    chk("rst_cursor_col", int'(cursor_col), 0);
    chk("rst_cursor_row", int'(cursor_row), 0);
    for (int a = 0; a < CELLS; a++) push_w(a, BLANK);
    rst = 1'b0;
    step();
    count_gap(CELLS);
    chk("post_clear_col", int'(cursor_col), 0);
    chk("post_clear_row", int'(cursor_row), 0);

    // back-to-back PUTs
    do_op(2'd0, 4'h5);
    do_op(2'd0, 4'h6);
    chk("b2b_col", int'(cursor_col), 2);

    // full line of PUTs from (0,0)
    do_op(2'd3, 4'h0);
    for (int i = 0; i < COLS; i++) do_op(2'd0, 4'hA);
    chk("line_row", int'(cursor_row), 1);
    chk("line_col", int'(cursor_col), 0);

    // NEWLINE at row 29, col 17 wraps to the top
    repeat (ROWS - 2) do_op(2'd1, 4'h0);
    for (int i = 0; i < 17; i++) do_op(2'd0, 4'($urandom_range(0, 15)));
    chk("pre_wrap_row", int'(cursor_row), ROWS - 1);
    do_op(2'd1, 4'h0);
    chk("wrap_row", int'(cursor_row), 0);

    // BACKSPACE across a row boundary, then at home
    do_op(2'd1, 4'h0);
    do_op(2'd1, 4'h0);
    do_op(2'd2, 4'h0);
    chk("bs_row", int'(cursor_row), 1);
    chk("bs_col", int'(cursor_col), COLS - 1);
    do_op(2'd3, 4'h0);
    do_op(2'd2, 4'h0);
    chk("bs_home_col", int'(cursor_col), 0);

    // randomized ops
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) do_op(2'd0, 4'($urandom_range(0, 15)));
      else if (r < 82) do_op(2'd2, 4'h0);
      else if (r < 98) do_op(2'd1, 4'h0);
      else do_op(2'd3, 4'h0);
    end

    // reset in the middle of a row clear
    accept_op(2'd1, 4'h0, gap);
    repeat (39) step();
    rst = 1'b1;
    op_r = 2'd0;
    char_r = 4'h7;
    valid = 1'b1;
    repeat (COLS - 40) void'(exp_q.pop_back());
    step();
    chk("abort_we", int'(we), 0);
    chk("abort_ready", int'(ready), 0);
    rst = 1'b0;
    m_row = 0;
    m_col = 0;
    for (int a = 0; a < CELLS; a++) push_w(a, BLANK);
    step();
    count_gap(CELLS);
    chk("abort_col", int'(cursor_col), 0);
    chk("abort_row", int'(cursor_row), 0);
    do_op(2'd0, 4'h7);
    chk("held_put_col", int'(cursor_col), 1);

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
